// File: rtl/mmio_timer_display.sv
// rtl/mmio_timer_display.sv - MMIO reloadable timer, LED register and scanned 4-digit 7-seg display
// Optional feature macro: MMIO_TIMER_IRQ_EN (stores TCON[1] and drives a registered irq)
module mmio_timer_display #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned SCAN_DIV  = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        hit,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irq
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

`ifdef MMIO_TIMER_IRQ_EN
  localparam logic [2:0] TCON_MASK = 3'b111;
`else
  localparam logic [2:0] TCON_MASK = 3'b101;
`endif

  logic [31:0]   th;
  logic [31:0]   tl;
  logic [2:0]    tcon;
  logic [15:0]   digi_val;
  logic [31:0]   systick;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    digit_idx;

  logic [2:0] sel;
  logic       wr_en;
  logic       tl_max;
  logic       overflow;
  logic [3:0] nibble;
  logic [7:0] seg;
  logic       unused_addr_bits;

  // Register window is word-aligned; byte offset bits carry no meaning here.
  assign unused_addr_bits = ^Address[1:0];

  assign sel      = Address[4:2];
  assign hit      = (Address[31:5] == BASE_ADDR[31:5]) && (sel <= 3'd5);
  assign wr_en    = MemWrite && hit;
  assign tl_max   = (tl == 32'hFFFF_FFFF);
  assign overflow = tcon[0] && tl_max;

  // Stores win over timer activity in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      th       <= 32'd0;
      tl       <= 32'd0;
      tcon     <= 3'd0;
      led      <= 8'd0;
      digi_val <= 16'd0;
      systick  <= 32'd0;
    end else begin
      systick <= systick + 32'd1;
      if (wr_en && sel == 3'd0) th <= Write_data;
      if (wr_en && sel == 3'd1) tl <= Write_data;
      else if (tcon[0])         tl <= tl_max ? th : tl + 32'd1;
      if (wr_en && sel == 3'd2) tcon <= Write_data[2:0] & TCON_MASK;
      else if (overflow)        tcon[2] <= 1'b1;
      if (wr_en && sel == 3'd3) led <= Write_data[7:0];
      if (wr_en && sel == 3'd4) digi_val <= Write_data[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    nibble = digi_val[3:0];
    case (digit_idx)
      2'd0: nibble = digi_val[3:0];
      2'd1: nibble = digi_val[7:4];
      2'd2: nibble = digi_val[11:8];
      2'd3: nibble = digi_val[15:12];
      default: nibble = digi_val[3:0];
    endcase
  end

  // Active-low {dp,g,f,e,d,c,b,a}; dp always off.
  always_comb begin
    seg = 8'hFF;
    case (nibble)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) digi <= 12'hEC0;
    else       digi <= {~(4'b0001 << digit_idx), seg};
  end

`ifdef MMIO_TIMER_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= tcon[1] & tcon[2];
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    Read_data = 32'd0;
    if (MemRead && hit) begin
      case (sel)
        3'd0: Read_data = th;
        3'd1: Read_data = tl;
        3'd2: Read_data = {29'd0, tcon};
        3'd3: Read_data = {24'd0, led};
        3'd4: Read_data = {16'd0, digi_val};
        3'd5: Read_data = systick;
        default: Read_data = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer_display.sv
// tb/tb_mmio_timer_display.sv - directed bench for mmio_timer_display with a cycle model and literal checks
// Honours MMIO_TIMER_IRQ_EN the same way as the design build.
module tb_mmio_timer_display;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          SDIV = 4;
  localparam logic [31:0] A_TH = BASE + 32'h00, A_TL = BASE + 32'h04, A_TCON = BASE + 32'h08;
  localparam logic [31:0] A_LED = BASE + 32'h0C, A_DIGI = BASE + 32'h10, A_TICK = BASE + 32'h14;

`ifdef MMIO_TIMER_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif
  localparam logic [31:0] TCON_OV = IRQ_BUILD ? 32'd7 : 32'd5;
  localparam logic [31:0] TCON_EN = IRQ_BUILD ? 32'd3 : 32'd1;
  localparam logic [31:0] TCON_B1 = IRQ_BUILD ? 32'd2 : 32'd0;

  localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  localparam logic [11:0] SCAN_SEQ [4] = '{12'hE8E, 12'hD80, 12'hB88, 12'h7F9};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = 32'd0;
  logic [31:0] Write_data = 32'd0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Read_data;
  logic        hit;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  mmio_timer_display #(.BASE_ADDR(BASE), .SCAN_DIV(SDIV)) dut (
    .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(Read_data), .hit(hit),
    .led(led), .digi(digi), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register file as plain variables, scan position from edge count.
  logic [31:0] m_th, m_tl, m_tick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led;
  logic [15:0] m_dv;
  logic [11:0] digi_exp;
  logic        irq_exp;
  int          n_edges;
  bit          model_valid = 1'b0;

  function automatic bit m_hit(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h18);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic rd);
    if (!rd || !m_hit(a)) return 32'd0;
    case ((a - BASE) >> 2)
      0: return m_th;
      1: return m_tl;
      2: return {29'd0, m_tcon};
      3: return {24'd0, m_led};
      4: return {16'd0, m_dv};
      5: return m_tick;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model_blk
    int          idx;
    logic [3:0]  an;
    logic [31:0] ntl;
    logic [2:0]  ntcon;
    int          reg_no;
    bit          we;
    if (reset) begin
      m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_dv = 0; m_tick = 0;
      n_edges = 0; digi_exp = 12'hEC0; irq_exp = 1'b0; model_valid = 1'b1;
    end else begin
      idx = (n_edges / SDIV) % 4;
      an = ~(4'b0001 << idx);
      digi_exp = {an, SEG[(m_dv >> (4 * idx)) & 16'hF]};
      irq_exp = IRQ_BUILD && m_tcon[1] && m_tcon[2];
      n_edges++;
      we = MemWrite && m_hit(Address);
      reg_no = int'((Address - BASE) >> 2);
      ntl = m_tl;
      ntcon = m_tcon;
      if (m_tcon[0]) begin
        if (m_tl == 32'hFFFF_FFFF) begin
          ntl = m_th;
          ntcon[2] = 1'b1;
        end else begin
          ntl = m_tl + 1;
        end
      end
      if (we && reg_no == 1) ntl = Write_data;
      if (we && reg_no == 2) ntcon = IRQ_BUILD ? Write_data[2:0] : (Write_data[2:0] & 3'b101);
      if (we && reg_no == 0) m_th = Write_data;
      if (we && reg_no == 3) m_led = Write_data[7:0];
      if (we && reg_no == 4) m_dv = Write_data[15:0];
      m_tl = ntl;
      m_tcon = ntcon;
      m_tick = m_tick + 1;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("led", 32'(led), 32'(m_led));
      check("digi", 32'(digi), 32'(digi_exp));
      check("irq", 32'(irq), 32'(irq_exp));
      check("hit", 32'(hit), 32'(m_hit(Address)));
      check("read_data", Read_data, m_read(Address, MemRead));
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address = a; Write_data = d; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    Address = a; MemRead = 1'b1;
    @(negedge clk);
    check(name, Read_data, exp);
    @(posedge clk); #1;
    MemRead = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    // 1. reset state and free-running SYSTICK
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_led", 32'(led), 32'h0);
    check("rst_digi", 32'(digi), 32'hEC0);
    check("rst_irq", 32'(irq), 32'h0);
    @(posedge clk); #1;
    rd(A_TICK, 32'd1, "tick1");
    rd(A_TICK, 32'd2, "tick2");
    rd(A_TICK, 32'd3, "tick3");

    // 2. overflow, reload and interrupt
    wr(A_TH, 32'd5);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd3);
    rd(A_TL, 32'hFFFF_FFFE, "tl_start");
    rd(A_TL, 32'hFFFF_FFFF, "tl_max");
    rd(A_TL, 32'd5, "tl_reload");
    rd(A_TCON, TCON_OV, "tcon_ov");
    check("irq_set", 32'(irq), 32'(IRQ_BUILD));
    wr(A_TCON, 32'd3);
    idle(1);
    check("irq_clr", 32'(irq), 32'd0);

    // store to TCON at the terminal cycle keeps the flag clear
    wr(A_TL, 32'hFFFF_FFFE);
    idle(1);
    wr(A_TCON, 32'd3);
    rd(A_TL, 32'd5, "tl_reload2");
    rd(A_TCON, TCON_EN, "tcon_noflag");

    // 3. store to TL at the terminal cycle beats the reload, flag still sets
    wr(A_TL, 32'hFFFF_FFFE);
    idle(1);
    wr(A_TL, 32'h100);
    rd(A_TL, 32'h100, "tl_store_wins");
    rd(A_TCON, TCON_OV, "tcon_flag_kept");

    // 4. scanner sequence from a known phase
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    wr(A_DIGI, 32'h1A8F);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("scan", 32'(digi), (k == 1) ? 32'hEC0 : 32'(SCAN_SEQ[((k - 1) / 4) % 4]));
    end
    @(posedge clk); #1;

    // 5. LED register and address window
    wr(A_LED, 32'hA5);
    check("led_a5", 32'(led), 32'hA5);
    rd(BASE + 32'h0F, 32'hA5, "led_byteoff");
    Address = BASE + 32'h20; MemRead = 1'b1;
    @(negedge clk);
    check("miss_hit", 32'(hit), 32'd0);
    check("miss_rd", Read_data, 32'd0);
    @(posedge clk); #1;
    MemRead = 1'b0;
    rd(BASE + 32'h18, 32'd0, "miss_18");
    wr(BASE + 32'h20, 32'hFFFF_FFFF);
    wr(A_TICK, 32'h0);
    rd(A_LED, 32'hA5, "led_keep");
    rd(A_TH, 32'd0, "th_keep");

    // 6. reset while counting and scanning
    wr(A_TCON, 32'd1);
    idle(6);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("r6_led", 32'(led), 32'd0);
    check("r6_digi", 32'(digi), 32'hEC0);
    rd(A_TICK, 32'd0, "r6_tick");
    rd(A_TL, 32'd0, "r6_tl");
    rd(A_TCON, 32'd0, "r6_tcon");
    rd(A_DIGI, 32'd0, "r6_digi_reg");
    wr(A_TCON, 32'd2);
    rd(A_TCON, TCON_B1, "tcon_bit1");
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
